// File: rtl/mux2_8b_gl_reg.sv
// rtl/mux2_8b_gl_reg.sv - gate-level 2:1 byte mux with a reset-cleared registered copy
// Optional parity outputs enabled by defining MUX2_8B_GL_PARITY_EN.
module mux2_8b_gl_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
`ifdef MUX2_8B_GL_PARITY_EN
    output logic             out_par,
    output logic             out_par_q,
`endif
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    wire sel_n;
    logic [WIDTH-1:0] out_d;

    not u_sel_inv (sel_n, sel);

    // Consensus term in0&in1 keeps a bit stable across sel edges (and under sel=X) when both inputs agree.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire both_w;
        wire pick0_w;
        wire pick1_w;
        wire bit_w;

        and u_both  (both_w,  in0[i], in1[i]);
        and u_pick0 (pick0_w, sel_n,  in0[i]);
        and u_pick1 (pick1_w, sel,    in1[i]);
        or  u_or    (bit_w,   both_w, pick0_w, pick1_w);

        assign out[i] = bit_w;
    end

    assign out_d = out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef MUX2_8B_GL_PARITY_EN
    logic par_d;

    assign par_d   = ^out;
    assign out_par = par_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_8b_gl_reg.sv
// tb/tb_mux2_8b_gl_reg.sv - self-checking bench for mux2_8b_gl_reg
module tb_mux2_8b_gl_reg;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] e;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       sel;
    logic [7:0] out;
    logic [7:0] out_q;
`ifdef MUX2_8B_GL_PARITY_EN
    logic       out_par;
    logic       out_par_q;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    mux2_8b_gl_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .in0   (in0),
        .in1   (in1),
        .sel   (sel),
`ifdef MUX2_8B_GL_PARITY_EN
        .out_par   (out_par),
        .out_par_q (out_par_q),
`endif
        .out   (out),
        .out_q (out_q)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t x;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got out_q=%b expected an entry", name, out_q);
        end else begin
            x = sb_q.pop_front();
            check8({name, "_out_q"}, out_q, x.data);
`ifdef MUX2_8B_GL_PARITY_EN
            check1({name, "_par_q"}, out_par_q, x.par);
`endif
        end
    endtask

    // Drive on negedge, check out combinationally, then check out_q after the next posedge.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] e, input string name);
        exp_t x;
        @(negedge clk);
        in0 = a;
        in1 = b;
        sel = s;
        #1;
        check8({name, "_out"}, out, e);
`ifdef MUX2_8B_GL_PARITY_EN
        check1({name, "_par"}, out_par, ^e);
`endif
        x.data = e;
        x.par  = ^e;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    initial begin
        exp_t x;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;

        tbl[0] = '{8'b00000000, 8'b00000000, 1'b0, 8'b00000000};
        tbl[1] = '{8'b00000000, 8'b00000000, 1'b1, 8'b00000000};
        tbl[2] = '{8'b00000000, 8'b11111111, 1'b0, 8'b00000000};
        tbl[3] = '{8'b00000000, 8'b11111111, 1'b1, 8'b11111111};
        tbl[4] = '{8'b10101010, 8'b01010101, 1'b0, 8'b10101010};
        tbl[5] = '{8'b10101010, 8'b01010101, 1'b1, 8'b01010101};
        tbl[6] = '{8'b10000001, 8'b01111110, 1'b0, 8'b10000001};
        tbl[7] = '{8'b10000001, 8'b01111110, 1'b1, 8'b01111110};
        tbl[8] = '{8'b01111111, 8'b10000000, 1'b0, 8'b01111111};
        tbl[9] = '{8'b01111111, 8'b10000000, 1'b1, 8'b10000000};

        reset = 1'b0;
        in0   = 8'hA5;
        in1   = 8'h3C;
        sel   = 1'b0;
        #2;
        check8("reset_out_q", out_q, 8'h00);
        check8("reset_out", out, 8'hA5);
        @(posedge clk);
        #1;
        check8("reset_hold_out_q", out_q, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
        end

        // in0==in1: output independent of sel
        apply(8'h5A, 8'h5A, 1'b0, 8'h5A, "eq_sel0");
        apply(8'h5A, 8'h5A, 1'b1, 8'h5A, "eq_sel1");

        // Asynchronous reset mid-cycle with out=11001100
        apply(8'b11001100, 8'b00110011, 1'b0, 8'b11001100, "pre_rst");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check8("async_rst_out_q", out_q, 8'h00);
        check8("async_rst_out", out, 8'b11001100);
`ifdef MUX2_8B_GL_PARITY_EN
        check1("async_rst_par_q", out_par_q, 1'b0);
`endif
        sb_q.delete();
        @(posedge clk);
        #1;
        check8("rst_held_out_q", out_q, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        x.data = 8'b11001100;
        x.par  = ^x.data;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        pop_check("rst_release");
        apply(8'b11001100, 8'b00110011, 1'b1, 8'b00110011, "post_rst_sel1");

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            apply(ra, rb, rs, rs ? rb : ra, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
